// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } rx_state_e;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   localparam logic [31:0] BR_MIN = 32'd4;

   function automatic logic [31:0] clamp_br(input logic [31:0] b);
      return (b < BR_MIN) ? BR_MIN : b;
   endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Two-flop line synchroniser with a 3-sample majority voter.
module uart_bit_sampler (
   input  logic clk,
   input  logic rst,
   input  logic rx_serial,
   input  logic vote,
   output logic rx_sync,
   output logic majority
);

   logic       sync1_q, sync1_d;
   logic       sync2_q, sync2_d;
   logic [1:0] tap_q, tap_d;

   always_comb begin
      sync1_d = rx_serial;
      sync2_d = sync1_q;
      tap_d   = tap_q;
      if (vote) begin
         tap_d = {tap_q[0], sync2_q};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         tap_q   <= 2'b11;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         tap_q   <= tap_d;
      end
   end

   // Third vote is the live sample, so the decision lands on count h+1.
   assign rx_sync  = sync2_q;
   assign majority = (tap_q[1] & tap_q[0]) |
                     (tap_q[1] & sync2_q)  |
                     (tap_q[0] & sync2_q);

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: 5..DATA_W data bits, parity,
// one or two stop bits, majority-voted sampling, error/break reporting.
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DIV_W  = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_serial,
   input  logic [DIV_W-1:0]  br_clocks,
   input  logic [3:0]        data_bits,
   input  logic [1:0]        parity_mode,
   input  logic              stop_bits,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_dv,
   output logic              parity_err,
   output logic              frame_err,
   output logic              rx_ready
);

   localparam logic [DIV_W-1:0] ONE = 1;
   localparam logic [3:0]       DW4 = 4'(DATA_W);

   rx_state_e         state_q, state_d;
   logic [DIV_W-1:0]  cnt_q, cnt_d;
   logic [DIV_W-1:0]  bdiv_q, bdiv_d;
   logic [3:0]        nbits_q, nbits_d;
   logic [1:0]        par_q, par_d;
   logic              two_stop_q, two_stop_d;
   logic [3:0]        bit_idx_q, bit_idx_d;
   logic              stop_idx_q, stop_idx_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic              acc_q, acc_d;
   logic              perr_q, perr_d;
   logic              ferr_q, ferr_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic              rx_dv_q, rx_dv_d;
   logic              parity_err_q, parity_err_d;
   logic              frame_err_q, frame_err_d;

   logic              line;
   logic              maj;
   logic              vote;
   logic [DIV_W-1:0]  half;
   logic              at_dec;
   logic              at_last;
   logic              in_win;
   logic [3:0]        nbits_cfg;
   logic [1:0]        par_cfg;

   uart_bit_sampler u_sampler (
      .clk       (clk),
      .rst       (rst),
      .rx_serial (rx_serial),
      .vote      (vote),
      .rx_sync   (line),
      .majority  (maj)
   );

   assign half    = bdiv_q >> 1;
   assign at_dec  = (cnt_q == half + ONE);
   assign at_last = (cnt_q == bdiv_q - ONE);
   assign in_win  = (cnt_q == half - ONE) || (cnt_q == half);

   assign nbits_cfg = (data_bits < 4'd5 || data_bits > DW4) ?
                      DW4 : data_bits;
   assign par_cfg   = (parity_mode == PAR_EVEN ||
                       parity_mode == PAR_ODD) ?
                      parity_mode : PAR_NONE;

   always_comb begin
      state_d      = state_q;
      cnt_d        = at_last ? '0 : cnt_q + ONE;
      bdiv_d       = bdiv_q;
      nbits_d      = nbits_q;
      par_d        = par_q;
      two_stop_d   = two_stop_q;
      bit_idx_d    = bit_idx_q;
      stop_idx_d   = stop_idx_q;
      shreg_d      = shreg_q;
      acc_d        = acc_q;
      perr_d       = perr_q;
      ferr_d       = ferr_q;
      rx_data_d    = rx_data_q;
      rx_dv_d      = 1'b0;
      parity_err_d = 1'b0;
      frame_err_d  = 1'b0;
      vote         = 1'b0;

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!line) begin
               state_d    = START;
               bdiv_d     = DIV_W'(clamp_br(32'(br_clocks)));
               nbits_d    = nbits_cfg;
               par_d      = par_cfg;
               two_stop_d = stop_bits;
               bit_idx_d  = '0;
               stop_idx_d = 1'b0;
               shreg_d    = '0;
               acc_d      = 1'b0;
               perr_d     = 1'b0;
               ferr_d     = 1'b0;
            end
         end
         START: begin
            vote = in_win;
            if (at_dec && maj) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (at_last) begin
               state_d = DATA;
            end
         end
         DATA: begin
            vote = in_win;
            if (at_dec) begin
               for (int i = 0; i < DATA_W; i++) begin
                  if (bit_idx_q == 4'(i)) shreg_d[i] = maj;
               end
               acc_d = acc_q ^ maj;
            end
            if (at_last) begin
               if (bit_idx_q == nbits_q - 4'd1) begin
                  state_d = (par_q == PAR_NONE) ? STOP : PARITY;
               end else begin
                  bit_idx_d = bit_idx_q + 4'd1;
               end
            end
         end
         PARITY: begin
            vote = in_win;
            if (at_dec) begin
               perr_d = acc_q ^ maj ^ (par_q == PAR_ODD);
            end
            if (at_last) state_d = STOP;
         end
         STOP: begin
            vote = in_win;
            // Final stop decision delivers the frame and frees the FSM early.
            if (at_dec && (stop_idx_q == two_stop_q)) begin
               rx_dv_d      = 1'b1;
               rx_data_d    = shreg_q;
               parity_err_d = perr_q;
               frame_err_d  = ferr_q | ~maj;
               state_d      = maj ? IDLE : BREAK;
               cnt_d        = '0;
            end else begin
               if (at_dec && !maj) ferr_d = 1'b1;
               if (at_last) stop_idx_d = 1'b1;
            end
         end
         BREAK: begin
            cnt_d = '0;
            if (line) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         bdiv_q       <= DIV_W'(BR_MIN);
         nbits_q      <= DW4;
         par_q        <= PAR_NONE;
         two_stop_q   <= 1'b0;
         bit_idx_q    <= '0;
         stop_idx_q   <= 1'b0;
         shreg_q      <= '0;
         acc_q        <= 1'b0;
         perr_q       <= 1'b0;
         ferr_q       <= 1'b0;
         rx_data_q    <= '0;
         rx_dv_q      <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bdiv_q       <= bdiv_d;
         nbits_q      <= nbits_d;
         par_q        <= par_d;
         two_stop_q   <= two_stop_d;
         bit_idx_q    <= bit_idx_d;
         stop_idx_q   <= stop_idx_d;
         shreg_q      <= shreg_d;
         acc_q        <= acc_d;
         perr_q       <= perr_d;
         ferr_q       <= ferr_d;
         rx_data_q    <= rx_data_d;
         rx_dv_q      <= rx_dv_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign rx_data    = rx_data_q;
   assign rx_dv      = rx_dv_q;
   assign parity_err = parity_err_q;
   assign frame_err  = frame_err_q;
   assign rx_ready   = (state_q == IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed self-checking bench for uart_rx_cfg.
module tb_uart_rx_cfg;

   localparam int DW = 8;
   localparam int VW = 15;

   logic          clk = 1'b0;
   logic          rst;
   logic          rx_serial;
   logic [VW-1:0] br_clocks;
   logic [3:0]    data_bits;
   logic [1:0]    parity_mode;
   logic          stop_bits;
   logic [DW-1:0] rx_data;
   logic          rx_dv;
   logic          parity_err;
   logic          frame_err;
   logic          rx_ready;

   uart_rx_cfg #(.DATA_W(DW), .DIV_W(VW)) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_serial   (rx_serial),
      .br_clocks   (br_clocks),
      .data_bits   (data_bits),
      .parity_mode (parity_mode),
      .stop_bits   (stop_bits),
      .rx_data     (rx_data),
      .rx_dv       (rx_dv),
      .parity_err  (parity_err),
      .frame_err   (frame_err),
      .rx_ready    (rx_ready)
   );

   always #5 clk = ~clk;

   int            tests  = 0;
   int            fails  = 0;
   int            dv_cnt = 0;
   int            bitlen = 16;
   logic [DW-1:0] last_data = '0;
   logic          last_pe = 1'b0;
   logic          last_fe = 1'b0;
   logic [DW-1:0] hist[$];

   always @(negedge clk) begin
      if (rx_dv === 1'b1) begin
         dv_cnt++;
         last_data = rx_data;
         last_pe   = parity_err;
         last_fe   = frame_err;
         hist.push_back(rx_data);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tx_bit(input logic b);
      rx_serial = b;
      repeat (bitlen) @(negedge clk);
   endtask

   task automatic tx_frame(input logic [8:0] d, input int n,
                           input int pbit, input logic s0,
                           input int ns, input logic s1);
      tx_bit(1'b0);
      for (int i = 0; i < n; i++) tx_bit(d[i]);
      if (pbit >= 0) tx_bit(pbit[0]);
      tx_bit(s0);
      if (ns == 2) tx_bit(s1);
   endtask

   task automatic idle(input int n);
      rx_serial = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst         = 1'b1;
      rx_serial   = 1'b1;
      br_clocks   = 15'd16;
      data_bits   = 4'd8;
      parity_mode = 2'b00;
      stop_bits   = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_data", 32'(rx_data), 32'h0);
      check("rst_dv", 32'(rx_dv), 32'h0);
      check("rst_pe", 32'(parity_err), 32'h0);
      check("rst_fe", 32'(frame_err), 32'h0);
      check("rst_ready", 32'(rx_ready), 32'h1);
      rst = 1'b0;
      idle(20);

      // 8N1 0xA5
      tx_frame(9'h0A5, 8, -1, 1'b1, 1, 1'b1);
      idle(32);
      check("a5_dv_cnt", 32'(dv_cnt), 32'd1);
      check("a5_data", 32'(last_data), 32'hA5);
      check("a5_pe", 32'(last_pe), 32'h0);
      check("a5_fe", 32'(last_fe), 32'h0);
      check("a5_ready", 32'(rx_ready), 32'h1);
      check("a5_dv_low", 32'(rx_dv), 32'h0);

      // 8E1 0x03 with parity bit 1 -> mismatch
      parity_mode = 2'b01;
      tx_frame(9'h003, 8, 1, 1'b1, 1, 1'b1);
      idle(32);
      check("e1_dv_cnt", 32'(dv_cnt), 32'd2);
      check("e1_data", 32'(last_data), 32'h03);
      check("e1_pe", 32'(last_pe), 32'h1);
      check("e1_pe_pulse", 32'(parity_err), 32'h0);

      // 8O1 0x03 with parity bit 1 -> ok
      parity_mode = 2'b10;
      tx_frame(9'h003, 8, 1, 1'b1, 1, 1'b1);
      idle(32);
      check("o1_dv_cnt", 32'(dv_cnt), 32'd3);
      check("o1_data", 32'(last_data), 32'h03);
      check("o1_pe", 32'(last_pe), 32'h0);

      // 3-cycle glitch in IDLE
      parity_mode = 2'b00;
      rx_serial = 1'b0;
      repeat (3) @(negedge clk);
      idle(48);
      check("glitch_dv_cnt", 32'(dv_cnt), 32'd3);
      check("glitch_ready", 32'(rx_ready), 32'h1);

      // 0x00 with a one-cycle spike mid data bit 2
      tx_bit(1'b0);
      tx_bit(1'b0);
      tx_bit(1'b0);
      rx_serial = 1'b0;
      repeat (9) @(negedge clk);
      rx_serial = 1'b1;
      @(negedge clk);
      rx_serial = 1'b0;
      repeat (6) @(negedge clk);
      for (int i = 3; i < 8; i++) tx_bit(1'b0);
      tx_bit(1'b1);
      idle(32);
      check("spike_dv_cnt", 32'(dv_cnt), 32'd4);
      check("spike_data", 32'(last_data), 32'h00);

      // br_clocks below minimum is clamped to 4
      br_clocks = 15'd2;
      bitlen    = 4;
      tx_frame(9'h05A, 8, -1, 1'b1, 1, 1'b1);
      idle(24);
      check("clamp_dv_cnt", 32'(dv_cnt), 32'd5);
      check("clamp_data", 32'(last_data), 32'h5A);
      br_clocks = 15'd16;
      bitlen    = 16;

      // 7N2 0x55, second stop bit low
      data_bits = 4'd7;
      stop_bits = 1'b1;
      tx_frame(9'h055, 7, -1, 1'b1, 2, 1'b0);
      idle(32);
      check("7n2_dv_cnt", 32'(dv_cnt), 32'd6);
      check("7n2_data", 32'(last_data), 32'h55);
      check("7n2_fe", 32'(last_fe), 32'h1);
      check("7n2_pe", 32'(last_pe), 32'h0);
      check("7n2_ready", 32'(rx_ready), 32'h1);

      // line held low for 20 bit times
      data_bits = 4'd8;
      stop_bits = 1'b0;
      rx_serial = 1'b0;
      repeat (20 * 16) @(negedge clk);
      check("brk_dv_cnt", 32'(dv_cnt), 32'd7);
      check("brk_data", 32'(last_data), 32'h00);
      check("brk_fe", 32'(last_fe), 32'h1);
      check("brk_ready_low", 32'(rx_ready), 32'h0);
      idle(8);
      check("brk_ready_high", 32'(rx_ready), 32'h1);
      idle(24);

      // async reset during data bit 4 of 0x3C
      tx_bit(1'b0);
      for (int i = 0; i < 4; i++) tx_bit(1'(8'h3C >> i));
      rx_serial = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_data", 32'(rx_data), 32'h0);
      check("mid_rst_dv", 32'(rx_dv), 32'h0);
      check("mid_rst_fe", 32'(frame_err), 32'h0);
      check("mid_rst_ready", 32'(rx_ready), 32'h1);
      @(negedge clk);
      rst = 1'b0;
      idle(48);
      check("mid_rst_dv_cnt", 32'(dv_cnt), 32'd7);

      tx_frame(9'h03C, 8, -1, 1'b1, 1, 1'b1);
      idle(32);
      check("post_dv_cnt", 32'(dv_cnt), 32'd8);
      check("post_data", 32'(last_data), 32'h3C);

      // back-to-back frames, zero idle gap
      tx_frame(9'h03C, 8, -1, 1'b1, 1, 1'b1);
      tx_frame(9'h0C3, 8, -1, 1'b1, 1, 1'b1);
      idle(32);
      check("b2b_dv_cnt", 32'(dv_cnt), 32'd10);
      check("b2b_first", 32'(hist[8]), 32'h3C);
      check("b2b_second", 32'(hist[9]), 32'hC3);
      check("b2b_fe", 32'(last_fe), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised, runtime-configurable UART receiver and successor to the fixed 8N1 receiver. It adds variable data width, optional even/odd parity, one or two stop bits, a two-flop input synchroniser, 3-sample majority voting at mid-bit, and parity/framing/break reporting. It sits between the serial pin and the byte-level consumer (FIFO or command parser), using the same clocks-per-bit divisor convention as the transmitter.

## Interface
- DATA_W, 8: maximum data bits per frame (5..9).
- DIV_W, 15: width of the clocks-per-bit divisor.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rx_serial  in  1  asynchronous serial line, idle high.
- br_clocks  in  DIV_W  clocks per bit; values < 4 are treated as 4.
- data_bits  in  4  data bits per frame; values outside 5..DATA_W are treated as DATA_W.
- parity_mode  in  2  parity selection: 00 none, 01 even, 10 odd, 11 treated as none.
- stop_bits  in  1  stop bits per frame: 0 selects one, 1 selects two.
- rx_data  out  DATA_W  received word, LSB first, unused upper bits 0.
- rx_dv  out  1  one-cycle strobe; rx_data and error flags are valid in the same cycle.
- parity_err  out  1  parity mismatch for the frame strobed by rx_dv.
- frame_err  out  1  a stop bit was sampled as 0.
- rx_ready  out  1  high only in IDLE.

## Operation
- Reset values: rx_data 0, rx_dv 0, parity_err 0, frame_err 0, rx_ready 1, FSM IDLE, synchroniser flops 1.
- Configuration inputs (br_clocks, data_bits, parity_mode, stop_bits) are latched on IDLE->START. Changes mid-frame are ignored.
- Bit timing: the per-bit counter runs 0..B-1, where B is the latched br_clocks. With h = B>>1, samples are taken at counts h-1, h and h+1. The majority of the three is the bit value, decided at count h+1.
- States:
  - IDLE: a synchronised 0 moves to START with counter 0.
  - START: if the majority is 1, return to IDLE silently (glitch, no flags). If 0, go to DATA.
  - DATA: shift in data_bits bits, LSB first. After the last bit, go to PARITY if enabled, else STOP.
  - PARITY: even parity requires XOR(data, p) = 0; odd parity requires it to be 1. The mismatch is held for the frame.
  - STOP: sample one or two stop bits; any 0 sets the pending frame error.
    - After the final stop decision, with no error, the next cycle pulses rx_dv and the FSM enters IDLE.
    - If the final stop bit is 0, rx_dv pulses and the FSM enters BREAK.
  - BREAK: wait for a synchronised 1, then enter IDLE. rx_ready stays 0 throughout.
- rx_dv, parity_err and frame_err are all one-cycle pulses, cleared the following cycle.
- rx_data holds its value until the next rx_dv.
- Data is always delivered, even when an error flag is set.
- Counter arithmetic is DIV_W wide and never wraps, because it resets at each bit boundary.

## Timing
- Input synchroniser latency is 2 clk.
- IDLE->START occurs 2 cycles after the pin falls.
- A frame occupies 1 + n + p + s bit periods from the start edge. Here n is the data bit count, p is 1 if parity is enabled (else 0), and s is the stop bit count.
- rx_dv fires 1 cycle after the final stop-bit decision, i.e. at count h+2 of the last stop bit.
- Back-to-back frames: IDLE is re-entered before the stop bit ends, so a start edge at the nominal stop end is accepted with zero idle gap.
- Asynchronous reset mid-frame aborts immediately to reset values, with no rx_dv.
- After reset release, a line that is already low is treated as a start edge.

## Structure
- Package uart_pkg: the state enum (IDLE, START, DATA, PARITY, STOP, BREAK), parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD), and a function clamping br_clocks to the minimum of 4.
- One sub-module, uart_bit_sampler: the two-flop synchroniser plus 3-tap majority register. It outputs the synchronised line and the majority value, with a `vote` enable driven by the FSM.

## Test plan
- br_clocks=16, 8N1, byte 0xA5 -> one rx_dv, rx_data=0xA5, parity_err=0, frame_err=0, rx_ready back to 1.
- 8E1, byte 0x03 with the parity bit forced to 1 -> rx_dv, rx_data=0x03, parity_err=1. Repeat as 8O1 with parity bit 1 -> parity_err=0.
- 3-cycle low glitch in IDLE at br_clocks=16 -> no rx_dv, FSM returns to IDLE.
- Single-cycle spike at count h inside data bit 2 of 0x00 -> rx_data=0x00 (majority filtered).
- data_bits=7, 7N2, byte 0x55, second stop bit driven 0 -> rx_data=0x55, frame_err=1. A line held low for 20 bit times -> rx_data=0x00, frame_err=1, rx_ready=0 until the line goes high.
- Assert rst during DATA bit 4 -> all outputs at reset values immediately. Next frame 0x3C received correctly, including two frames back-to-back with zero idle gap.
